// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam logic [4:0] REG_ZERO        = 5'd0;
   localparam int         DEF_CNT_W       = 16;
   localparam int         DEF_MEM_TIMEOUT = 64;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != '1)) begin
         cnt_o <= cnt_o + W'(1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, ID branch
// flushes and full freezes for multi-cycle data-memory accesses.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             id_branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             pc_write_o,
   output logic             if_id_write_o,
   output logic             if_id_flush_o,
   output logic             id_ex_noop_o,
   output logic             pipe_stall_o,
   output logic [1:0]       state_o,
   output logic             err_o,
   output logic [CNT_W-1:0] load_use_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [CNT_W-1:0] mem_wait_cnt_o
);

   localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   state_t            state;
   state_t            state_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_next;
   logic              err;
   logic              err_next;
   logic              haz;
   logic              mstall;
   logic              load_use_inc;
   logic              flush_inc;

   assign haz = ex_memread_i & (ex_rd_i != REG_ZERO) &
                ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                 (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
   assign mstall = mem_req_i & ~mem_ack_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
         err      <= err_next;
      end
   end

   // wait_next tracks the length of the current freeze, so the timeout
   // flags on the very edge that completes the MEM_TIMEOUT-th freeze cycle.
   always_comb begin
      state_next = state;
      wait_next  = wait_cnt;
      case (state)
         IDLE: begin
            if (start_i) state_next = RUN;
         end
         RUN: begin
            if (mstall) begin
               state_next = MEM_WAIT;
               wait_next  = WAIT_W'(1);
            end else if (!start_i) begin
               state_next = IDLE;
            end
         end
         MEM_WAIT: begin
            if (mem_ack_i) begin
               state_next = start_i ? RUN : IDLE;
            end else if (wait_cnt != WAIT_MAX) begin
               wait_next = wait_cnt + WAIT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
      err_next = err | (pipe_stall_o & (wait_next == WAIT_MAX));
   end

   always_comb begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      if_id_flush_o = 1'b0;
      id_ex_noop_o  = 1'b0;
      pipe_stall_o  = 1'b0;
      load_use_inc  = 1'b0;
      flush_inc     = 1'b0;
      case (state)
         RUN: begin
            if (mstall) begin
               pipe_stall_o = 1'b1;
            end else if (haz) begin
               id_ex_noop_o = 1'b1;
               load_use_inc = 1'b1;
            end else if (id_branch_taken_i) begin
               pc_write_o    = 1'b1;
               if_id_write_o = 1'b1;
               if_id_flush_o = 1'b1;
               flush_inc     = 1'b1;
            end else begin
               pc_write_o    = 1'b1;
               if_id_write_o = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ack_i) begin
               pc_write_o    = 1'b1;
               if_id_write_o = 1'b1;
            end else begin
               pipe_stall_o = 1'b1;
            end
         end
         default: id_ex_noop_o = 1'b1;
      endcase
   end

   assign state_o = state;
   assign err_o   = err;

   sat_counter #(.W(CNT_W)) u_load_use_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (load_use_inc),
      .cnt_o (load_use_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (flush_inc),
      .cnt_o (flush_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (pipe_stall_o),
      .cnt_o (mem_wait_cnt_o)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed
// by random traffic, all compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 8;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   typedef struct {
      logic       start;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use1;
      logic       use2;
      logic       memread;
      logic [4:0] rd;
      logic       br;
      logic       req;
      logic       ack;
      logic       rst;
   } stim_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic             use1;
   logic             use2;
   logic             memread;
   logic [4:0]       exrd;
   logic             br;
   logic             req;
   logic             ack;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_noop;
   logic             pipe_stall;
   logic [1:0]       state;
   logic             err;
   logic [CNT_W-1:0] load_use_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] mem_wait_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0=idle,1=run,2=waiting on memory; freeze_len is the
   // length of the current unbroken run of frozen cycles.
   int m_mode       = 0;
   int m_freeze_len = 0;
   int m_err        = 0;
   int m_lu         = 0;
   int m_fl         = 0;
   int m_mw         = 0;

   stim_t st;

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .start_i           (start),
      .id_rs1_i          (rs1),
      .id_rs2_i          (rs2),
      .id_use_rs1_i      (use1),
      .id_use_rs2_i      (use2),
      .ex_memread_i      (memread),
      .ex_rd_i           (exrd),
      .id_branch_taken_i (br),
      .mem_req_i         (req),
      .mem_ack_i         (ack),
      .pc_write_o        (pc_write),
      .if_id_write_o     (if_id_write),
      .if_id_flush_o     (if_id_flush),
      .id_ex_noop_o      (id_ex_noop),
      .pipe_stall_o      (pipe_stall),
      .state_o           (state),
      .err_o             (err),
      .load_use_cnt_o    (load_use_cnt),
      .flush_cnt_o       (flush_cnt),
      .mem_wait_cnt_o    (mem_wait_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic stim_t quiet();
      stim_t s;
      s.start   = 1'b1;
      s.rs1     = 5'd0;
      s.rs2     = 5'd0;
      s.use1    = 1'b0;
      s.use2    = 1'b0;
      s.memread = 1'b0;
      s.rd      = 5'd0;
      s.br      = 1'b0;
      s.req     = 1'b0;
      s.ack     = 1'b0;
      s.rst     = 1'b0;
      return s;
   endfunction

   task automatic applyStimulus(input stim_t s);
      @(negedge clk);
      start   = s.start;
      rs1     = s.rs1;
      rs2     = s.rs2;
      use1    = s.use1;
      use2    = s.use2;
      memread = s.memread;
      exrd    = s.rd;
      br      = s.br;
      req     = s.req;
      ack     = s.ack;
      rst     = s.rst;
      #1;
   endtask

   function automatic int satInc(input int v, input int inc);
      return (inc != 0 && v < CNT_MAX) ? v + 1 : v;
   endfunction

   // Compare every output against the model for the current inputs, then
   // advance the model across the next rising edge.
   task automatic runCycle();
      int  e_pc, e_ifw, e_fl, e_noop, e_st;
      bit  dep, frozen_req;
      dep = (memread == 1'b1) && (exrd != 5'd0) &&
            ((use1 == 1'b1 && rs1 == exrd) || (use2 == 1'b1 && rs2 == exrd));
      frozen_req = (req == 1'b1) && (ack == 1'b0);
      e_pc = 0; e_ifw = 0; e_fl = 0; e_noop = 0; e_st = 0;
      if (m_mode == 0) begin
         e_noop = 1;
      end else if (m_mode == 1) begin
         if (frozen_req)          e_st = 1;
         else if (dep)            e_noop = 1;
         else if (br == 1'b1)     begin e_pc = 1; e_ifw = 1; e_fl = 1; end
         else                     begin e_pc = 1; e_ifw = 1; end
      end else begin
         if (ack == 1'b1)         begin e_pc = 1; e_ifw = 1; end
         else                     e_st = 1;
      end

      checkOutput("pc_write",     32'(pc_write),     32'(e_pc));
      checkOutput("if_id_write",  32'(if_id_write),  32'(e_ifw));
      checkOutput("if_id_flush",  32'(if_id_flush),  32'(e_fl));
      checkOutput("id_ex_noop",   32'(id_ex_noop),   32'(e_noop));
      checkOutput("pipe_stall",   32'(pipe_stall),   32'(e_st));
      checkOutput("state",        32'(state),        32'(m_mode));
      checkOutput("err",          32'(err),          32'(m_err));
      checkOutput("load_use_cnt", 32'(load_use_cnt), 32'(m_lu));
      checkOutput("flush_cnt",    32'(flush_cnt),    32'(m_fl));
      checkOutput("mem_wait_cnt", 32'(mem_wait_cnt), 32'(m_mw));

      @(posedge clk);
      if (rst == 1'b1) begin
         m_mode = 0; m_freeze_len = 0; m_err = 0;
         m_lu = 0; m_fl = 0; m_mw = 0;
      end else begin
         m_lu = satInc(m_lu, (m_mode == 1 && !frozen_req && dep) ? 1 : 0);
         m_fl = satInc(m_fl, (m_mode == 1 && !frozen_req && !dep && br == 1'b1) ? 1 : 0);
         m_mw = satInc(m_mw, e_st);
         m_freeze_len = (e_st != 0) ? m_freeze_len + 1 : 0;
         if (m_freeze_len >= MEM_TIMEOUT) m_err = 1;
         case (m_mode)
            0:       m_mode = (start == 1'b1) ? 1 : 0;
            1:       m_mode = frozen_req ? 2 : ((start == 1'b1) ? 1 : 0);
            default: m_mode = (ack == 1'b1) ? ((start == 1'b1) ? 1 : 0) : 2;
         endcase
      end
      #1;
   endtask

   initial begin
      st = quiet();
      st.start = 1'b0;
      st.rst   = 1'b1;
      start = st.start; rs1 = st.rs1; rs2 = st.rs2; use1 = st.use1; use2 = st.use2;
      memread = st.memread; exrd = st.rd; br = st.br; req = st.req; ack = st.ack; rst = st.rst;
      @(posedge clk);
      applyStimulus(st);
      runCycle();

      st = quiet();
      applyStimulus(st);
      checkOutput("idle_state", 32'(state), 32'd0);
      checkOutput("idle_pc_write", 32'(pc_write), 32'd0);
      runCycle();

      applyStimulus(st);
      checkOutput("run_state", 32'(state), 32'd1);
      checkOutput("run_pc_write", 32'(pc_write), 32'd1);
      checkOutput("run_lu_cnt_zero", 32'(load_use_cnt), 32'd0);
      runCycle();

      st = quiet();
      st.memread = 1'b1; st.rd = 5'd5; st.rs2 = 5'd5; st.use2 = 1'b1; st.br = 1'b1;
      applyStimulus(st);
      checkOutput("lu_noop", 32'(id_ex_noop), 32'd1);
      checkOutput("lu_pc_write", 32'(pc_write), 32'd0);
      checkOutput("lu_flush_suppressed", 32'(if_id_flush), 32'd0);
      runCycle();
      checkOutput("lu_cnt_one", 32'(load_use_cnt), 32'd1);

      st.rd = 5'd0; st.rs2 = 5'd0;
      applyStimulus(st);
      checkOutput("rd0_no_noop", 32'(id_ex_noop), 32'd0);
      checkOutput("rd0_pc_write", 32'(pc_write), 32'd1);
      runCycle();

      st = quiet();
      st.br = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(st);
         checkOutput("branch_flush", 32'(if_id_flush), 32'd1);
         runCycle();
      end
      checkOutput("flush_cnt_after_branches", 32'(flush_cnt), 32'd4);

      st = quiet();
      st.req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(st);
         checkOutput("mem_freeze", 32'(pipe_stall), 32'd1);
         runCycle();
      end
      st.ack = 1'b1;
      applyStimulus(st);
      checkOutput("mem_ack_no_stall", 32'(pipe_stall), 32'd0);
      checkOutput("mem_ack_pc_write", 32'(pc_write), 32'd1);
      runCycle();
      checkOutput("mem_wait_cnt_four", 32'(mem_wait_cnt), 32'd4);
      checkOutput("mem_back_to_run", 32'(state), 32'd1);

      st = quiet();
      st.req = 1'b1;
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         applyStimulus(st);
         runCycle();
         if (i == MEM_TIMEOUT - 2) checkOutput("err_not_yet", 32'(err), 32'd0);
      end
      checkOutput("err_at_timeout", 32'(err), 32'd1);
      checkOutput("still_frozen", 32'(state), 32'd2);
      st.req = 1'b0; st.ack = 1'b1;
      applyStimulus(st);
      runCycle();
      checkOutput("err_sticky", 32'(err), 32'd1);
      st = quiet();
      st.rst = 1'b1;
      applyStimulus(st);
      runCycle();
      checkOutput("err_cleared", 32'(err), 32'd0);
      checkOutput("reset_state", 32'(state), 32'd0);

      st = quiet();
      applyStimulus(st);
      runCycle();
      st.memread = 1'b1; st.rd = 5'd3; st.rs1 = 5'd3; st.use1 = 1'b1;
      for (int i = 0; i < CNT_MAX + 2; i++) begin
         applyStimulus(st);
         runCycle();
      end
      checkOutput("lu_cnt_saturated", 32'(load_use_cnt), 32'(CNT_MAX));

      for (int i = 0; i < 3000; i++) begin
         st.start   = ($urandom_range(9) != 0);
         st.rs1     = 5'($urandom_range(3));
         st.rs2     = 5'($urandom_range(3));
         st.use1    = 1'($urandom_range(1));
         st.use2    = 1'($urandom_range(1));
         st.memread = 1'($urandom_range(1));
         st.rd      = 5'($urandom_range(3));
         st.br      = 1'($urandom_range(1));
         st.req     = ($urandom_range(3) == 0);
         st.ack     = ($urandom_range((i % 500 < 100) ? 15 : 2) == 0);
         st.rst     = ($urandom_range(299) == 0);
         applyStimulus(st);
         runCycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
